// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: allocation payload, retire payload and sizing constants.
package reorder_buffer_pkg;

   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned ROB_IDX_W = 4;
   localparam int unsigned PREG_W    = 7;
   localparam int unsigned PC_W      = 32;
   localparam int unsigned ROB_TAG_W = 5;

   typedef struct packed {
      logic                 valid;
      logic                 complete;
      logic [ROB_TAG_W-1:0] rob_index;
      logic [PREG_W-1:0]    pd_new;
      logic [PREG_W-1:0]    pd_old;
      logic [PC_W-1:0]      pc;
   } rob_data;

   typedef struct packed {
      logic [PREG_W-1:0]    pd_old;
      logic [PREG_W-1:0]    pd_new;
      logic [PC_W-1:0]      pc;
      logic [ROB_IDX_W-1:0] rob_index;
   } rob_retire_data;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order completion, in-order retire,
// and branch-flush squash of every entry younger than the mispredicted branch.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = ROB_DEPTH,
   parameter int unsigned NUM_WB = 3
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     alloc_valid,
   input  rob_data                                  alloc_data,
   output logic                                     alloc_ready,
   output logic [$clog2(DEPTH)-1:0]                 alloc_index,
   input  logic [NUM_WB-1:0]                        wb_valid,
   input  logic [NUM_WB-1:0][$clog2(DEPTH)-1:0]     wb_index,
   input  logic                                     flush_valid,
   input  logic [$clog2(DEPTH)-1:0]                 flush_index,
   output logic                                     retire_valid,
   output logic [PREG_W-1:0]                        retire_pd_old,
   output logic [PREG_W-1:0]                        retire_pd_new,
   output logic [PC_W-1:0]                          retire_pc,
   output logic [$clog2(DEPTH)-1:0]                 retire_index,
   output logic                                     full,
   output logic                                     empty,
   output logic [$clog2(DEPTH):0]                   count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   rob_data          entries [DEPTH];
   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [IDX_W-1:0] flush_dist;
   logic [DEPTH-1:0] squash;
   logic [DEPTH-1:0] wb_hit;
   logic             alloc_fire;
   logic             retire_fire;
   rob_retire_data   retire_q;
   logic             unused_alloc_fields;

   // True when idx lies strictly between fi and tl, walking forward mod DEPTH.
   function automatic logic in_flush_range(input logic [IDX_W-1:0] idx,
                                           input logic [IDX_W-1:0] fi,
                                           input logic [IDX_W-1:0] tl);
      logic [IDX_W-1:0] d_idx;
      logic [IDX_W-1:0] d_tail;
      d_idx  = idx - fi - IDX_W'(1);
      d_tail = tl - fi - IDX_W'(1);
      return d_idx < d_tail;
   endfunction

   assign unused_alloc_fields = ^{alloc_data.valid, alloc_data.complete, alloc_data.rob_index};

   assign full        = (count_q == CNT_W'(DEPTH));
   assign empty       = (count_q == '0);
   assign count       = count_q;
   assign alloc_ready = !full && !flush_valid;
   assign alloc_index = tail;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign retire_fire = entries[head].valid && entries[head].complete;
   assign flush_dist  = flush_index - head;

   // Squash mask and OR-merged writeback hits across all ports.
   always_comb begin
      squash = '0;
      wb_hit = '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
         squash[e] = flush_valid && in_flush_range(IDX_W'(e), flush_index, tail);
      end
      for (int unsigned w = 0; w < NUM_WB; w++) begin
         if (wb_valid[w]) wb_hit[wb_index[w]] = 1'b1;
      end
   end

   always_comb begin
      count_d = count_q;
      if (flush_valid) begin
         count_d = CNT_W'(flush_dist) + CNT_W'(1) - CNT_W'(retire_fire);
      end else begin
         count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(retire_fire);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head         <= '0;
         tail         <= '0;
         count_q      <= '0;
         retire_valid <= 1'b0;
         retire_q     <= '0;
         for (int unsigned e = 0; e < DEPTH; e++) begin
            entries[e] <= '0;
         end
      end else begin
         // Squash outranks writeback so a same-cycle completion to a squashed entry is lost.
         for (int unsigned e = 0; e < DEPTH; e++) begin
            if (squash[e]) begin
               entries[e].valid    <= 1'b0;
               entries[e].complete <= 1'b0;
            end else if (wb_hit[e] && entries[e].valid) begin
               entries[e].complete <= 1'b1;
            end
         end
         if (retire_fire) begin
            entries[head].valid    <= 1'b0;
            entries[head].complete <= 1'b0;
            head                   <= head + IDX_W'(1);
            retire_q.pd_old        <= entries[head].pd_old;
            retire_q.pd_new        <= entries[head].pd_new;
            retire_q.pc            <= entries[head].pc;
            retire_q.rob_index     <= ROB_IDX_W'(entries[head].rob_index);
         end
         if (alloc_fire) begin
            entries[tail].valid     <= 1'b1;
            entries[tail].complete  <= 1'b0;
            entries[tail].rob_index <= ROB_TAG_W'(tail);
            entries[tail].pd_new    <= alloc_data.pd_new;
            entries[tail].pd_old    <= alloc_data.pd_old;
            entries[tail].pc        <= alloc_data.pc;
            tail                    <= tail + IDX_W'(1);
         end
         if (flush_valid) tail <= flush_index + IDX_W'(1);
         retire_valid <= retire_fire;
         count_q      <= count_d;
      end
   end

   assign retire_pd_old = retire_q.pd_old;
   assign retire_pd_new = retire_q.pd_new;
   assign retire_pc     = retire_q.pc;
   assign retire_index  = IDX_W'(retire_q.rob_index);

   // A flush must name a live entry; anything else is a dispatch protocol error.
   flush_target_valid: assert property (@(posedge clk) disable iff (!rst_n)
                                        flush_valid |-> entries[flush_index].valid);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic             clk;
   logic             rst_n;
   logic             alloc_valid;
   rob_data          alloc_data;
   logic             alloc_ready;
   logic [3:0]       alloc_index;
   logic [2:0]       wb_valid;
   logic [2:0][3:0]  wb_index;
   logic             flush_valid;
   logic [3:0]       flush_index;
   logic             retire_valid;
   logic [6:0]       retire_pd_old;
   logic [6:0]       retire_pd_new;
   logic [31:0]      retire_pc;
   logic [3:0]       retire_index;
   logic             full;
   logic             empty;
   logic [4:0]       count;

   int checks;
   int errors;

   reorder_buffer #(.DEPTH(16), .NUM_WB(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_data(alloc_data),
      .alloc_ready(alloc_ready), .alloc_index(alloc_index),
      .wb_valid(wb_valid), .wb_index(wb_index),
      .flush_valid(flush_valid), .flush_index(flush_index),
      .retire_valid(retire_valid), .retire_pd_old(retire_pd_old),
      .retire_pd_new(retire_pd_new), .retire_pc(retire_pc),
      .retire_index(retire_index), .full(full), .empty(empty), .count(count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_valid = 1'b0;
      alloc_data  = '0;
      wb_valid    = '0;
      wb_index    = '0;
      flush_valid = 1'b0;
      flush_index = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_alloc(input logic [31:0] pc, input logic [6:0] pdn, input logic [6:0] pdo);
      alloc_valid          = 1'b1;
      alloc_data           = '0;
      alloc_data.pc        = pc;
      alloc_data.pd_new    = pdn;
      alloc_data.pd_old    = pdo;
      alloc_data.rob_index = 5'h1F;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      checks++;
      if (retire_valid !== 1'b0) begin errors++; $display("FAIL reset_retire_in_reset: got %0b expected 0", retire_valid); end
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
      checks++;
      if (alloc_index !== 4'd0) begin errors++; $display("FAIL reset_alloc_index: got %0d expected 0", alloc_index); end
      checks++;
      if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b expected 1", alloc_ready); end
      checks++;
      if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++;
      if (retire_pc !== 32'd0 || retire_pd_old !== 7'd0 || retire_index !== 4'd0)
         begin errors++; $display("FAIL reset_retire_regs: got pc=%0h pdo=%0d idx=%0d expected 0", retire_pc, retire_pd_old, retire_index); end
   endtask

   task automatic test_basic_retire();
      set_alloc(32'h100, 7'd33, 7'd5);
      alloc_data.complete = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (count !== 5'd1 || alloc_index !== 4'd1) begin errors++; $display("FAIL basic_after_alloc: got count=%0d idx=%0d expected 1 1", count, alloc_index); end
      tick();
      checks++;
      if (retire_valid !== 1'b0) begin errors++; $display("FAIL basic_no_early_retire: got %0b expected 0", retire_valid); end
      wb_valid[0] = 1'b1;
      wb_index[0] = 4'd0;
      tick();
      idle_inputs();
      checks++;
      if (retire_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass: got %0b expected 0", retire_valid); end
      tick();
      checks++;
      if (retire_valid !== 1'b1 || retire_pd_old !== 7'd5 || retire_pd_new !== 7'd33 || retire_pc !== 32'h100 || retire_index !== 4'd0)
         begin errors++; $display("FAIL basic_retire: got v=%0b pdo=%0d pdn=%0d pc=%0h idx=%0d expected 1 5 33 100 0",
                                  retire_valid, retire_pd_old, retire_pd_new, retire_pc, retire_index); end
      checks++;
      if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL basic_count: got %0d expected 0", count); end
      tick();
      checks++;
      if (retire_valid !== 1'b0 || retire_pd_old !== 7'd5) begin errors++; $display("FAIL basic_hold: got v=%0b pdo=%0d expected 0 5", retire_valid, retire_pd_old); end
   endtask

   task automatic test_fill_full();
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         set_alloc(32'(i * 4), 7'(i), 7'(i + 16));
         checks++;
         if (alloc_index !== 4'(i) || alloc_ready !== 1'b1)
            begin errors++; $display("FAIL fill_index_%0d: got idx=%0d rdy=%0b expected %0d 1", i, alloc_index, alloc_ready, i); end
         tick();
      end
      set_alloc(32'hDEAD, 7'd99, 7'd98);
      checks++;
      if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 5'd16)
         begin errors++; $display("FAIL fill_full: got full=%0b rdy=%0b count=%0d expected 1 0 16", full, alloc_ready, count); end
      tick();
      alloc_valid = 1'b0;
      checks++;
      if (alloc_index !== 4'd0 || count !== 5'd16) begin errors++; $display("FAIL fill_reject: got idx=%0d count=%0d expected 0 16", alloc_index, count); end
      wb_valid[0] = 1'b1;
      wb_index[0] = 4'd0;
      tick();
      idle_inputs();
      checks++;
      if (full !== 1'b1) begin errors++; $display("FAIL fill_still_full: got %0b expected 1", full); end
      tick();
      checks++;
      if (retire_valid !== 1'b1 || retire_pd_old !== 7'd16 || retire_pc !== 32'd0)
         begin errors++; $display("FAIL fill_retire_head: got v=%0b pdo=%0d pc=%0h expected 1 16 0", retire_valid, retire_pd_old, retire_pc); end
      checks++;
      if (alloc_ready !== 1'b1 || count !== 5'd15 || full !== 1'b0)
         begin errors++; $display("FAIL fill_freed: got rdy=%0b count=%0d full=%0b expected 1 15 0", alloc_ready, count, full); end
   endtask

   task automatic test_out_of_order();
      logic [3:0] order [3];
      order[0] = 4'd3; order[1] = 4'd1; order[2] = 4'd2;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         set_alloc(32'(32'h200 + i * 4), 7'(40 + i), 7'(50 + i));
         tick();
      end
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         wb_valid[0] = 1'b1;
         wb_index[0] = order[i];
         tick();
         checks++;
         if (retire_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_retire_%0d: got %0b expected 0", i, retire_valid); end
      end
      wb_index[0] = 4'd0;
      tick();
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (retire_valid !== 1'b1 || retire_index !== 4'(k) || retire_pd_old !== 7'(50 + k))
            begin errors++; $display("FAIL ooo_retire_%0d: got v=%0b idx=%0d pdo=%0d expected 1 %0d %0d", k, retire_valid, retire_index, retire_pd_old, k, 50 + k); end
      end
      tick();
      checks++;
      if (retire_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL ooo_drained: got v=%0b empty=%0b expected 0 1", retire_valid, empty); end
   endtask

   task automatic test_flush_wrap();
      logic [3:0] idx;
      apply_reset();
      for (int i = 0; i < 14; i++) begin
         set_alloc(32'(i), 7'(i), 7'(i));
         tick();
      end
      idle_inputs();
      for (int i = 0; i < 14; i++) begin
         wb_valid[0] = 1'b1;
         wb_index[0] = 4'(i);
         tick();
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (empty !== 1'b1 || alloc_index !== 4'd14) begin errors++; $display("FAIL flush_setup: got empty=%0b idx=%0d expected 1 14", empty, alloc_index); end
      for (int i = 0; i < 5; i++) begin
         idx = 4'(14 + i);
         set_alloc(32'h300 + 32'(idx), 7'(60 + i), 7'(70 + i));
         tick();
      end
      idle_inputs();
      checks++;
      if (count !== 5'd5 || alloc_index !== 4'd3) begin errors++; $display("FAIL flush_prefill: got count=%0d idx=%0d expected 5 3", count, alloc_index); end
      flush_valid = 1'b1;
      flush_index = 4'd15;
      #1;
      checks++;
      if (alloc_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_alloc: got %0b expected 0", alloc_ready); end
      tick();
      idle_inputs();
      checks++;
      if (alloc_index !== 4'd0 || count !== 5'd2) begin errors++; $display("FAIL flush_wrap_state: got tail=%0d count=%0d expected 0 2", alloc_index, count); end
      wb_valid = 3'b111;
      wb_index[0] = 4'd0; wb_index[1] = 4'd1; wb_index[2] = 4'd2;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (retire_valid !== 1'b0 || count !== 5'd2) begin errors++; $display("FAIL flush_dead_wb: got v=%0b count=%0d expected 0 2", retire_valid, count); end
      wb_valid = 3'b011;
      wb_index[0] = 4'd14; wb_index[1] = 4'd15;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (retire_valid !== 1'b1 || retire_index !== 4'd14 || retire_pd_old !== 7'd70)
         begin errors++; $display("FAIL flush_retire_14: got v=%0b idx=%0d pdo=%0d expected 1 14 70", retire_valid, retire_index, retire_pd_old); end
      tick();
      checks++;
      if (retire_valid !== 1'b1 || retire_index !== 4'd15) begin errors++; $display("FAIL flush_retire_15: got v=%0b idx=%0d expected 1 15", retire_valid, retire_index); end
      tick();
      checks++;
      if (retire_valid !== 1'b0 || empty !== 1'b1 || count !== 5'd0)
         begin errors++; $display("FAIL flush_end_empty: got v=%0b empty=%0b count=%0d expected 0 1 0", retire_valid, empty, count); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         set_alloc(32'h400 + 32'(i), 7'(80 + i), 7'(90 + i));
         tick();
      end
      idle_inputs();
      wb_valid[0] = 1'b1;
      wb_index[0] = 4'd0;
      tick();
      set_alloc(32'hBEEF, 7'd1, 7'd2);
      flush_valid = 1'b1;
      flush_index = 4'd0;
      wb_valid[0] = 1'b1;
      wb_index[0] = 4'd1;
      #1;
      checks++;
      if (alloc_ready !== 1'b0) begin errors++; $display("FAIL simul_alloc_ready: got %0b expected 0", alloc_ready); end
      tick();
      idle_inputs();
      checks++;
      if (retire_valid !== 1'b1 || retire_index !== 4'd0 || retire_pd_old !== 7'd90)
         begin errors++; $display("FAIL simul_retire: got v=%0b idx=%0d pdo=%0d expected 1 0 90", retire_valid, retire_index, retire_pd_old); end
      checks++;
      if (count !== 5'd0 || empty !== 1'b1 || alloc_index !== 4'd1)
         begin errors++; $display("FAIL simul_state: got count=%0d empty=%0b tail=%0d expected 0 1 1", count, empty, alloc_index); end
      set_alloc(32'h500, 7'd3, 7'd4);
      tick();
      idle_inputs();
      tick();
      tick();
      checks++;
      if (retire_valid !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL simul_squashed_wb: got v=%0b count=%0d expected 0 1", retire_valid, count); end
   endtask

   task automatic test_multi_wb();
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         set_alloc(32'h600 + 32'(i), 7'(i), 7'(100 + i));
         tick();
      end
      idle_inputs();
      wb_valid = 3'b111;
      wb_index[0] = 4'd4; wb_index[1] = 4'd4; wb_index[2] = 4'd5;
      tick();
      checks++;
      if (retire_valid !== 1'b0) begin errors++; $display("FAIL mwb_no_retire: got %0b expected 0", retire_valid); end
      wb_index[0] = 4'd0; wb_index[1] = 4'd1; wb_index[2] = 4'd2;
      tick();
      wb_valid = 3'b001;
      wb_index[0] = 4'd3;
      tick();
      idle_inputs();
      checks++;
      if (retire_valid !== 1'b1 || retire_index !== 4'd0) begin errors++; $display("FAIL mwb_retire_0: got v=%0b idx=%0d expected 1 0", retire_valid, retire_index); end
      for (int k = 1; k < 6; k++) begin
         tick();
         checks++;
         if (retire_valid !== 1'b1 || retire_index !== 4'(k) || retire_pd_old !== 7'(100 + k))
            begin errors++; $display("FAIL mwb_retire_%0d: got v=%0b idx=%0d pdo=%0d expected 1 %0d %0d", k, retire_valid, retire_index, retire_pd_old, k, 100 + k); end
      end
      tick();
      checks++;
      if (retire_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL mwb_drained: got v=%0b empty=%0b expected 0 1", retire_valid, empty); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_basic_retire();
      test_fill_full();
      test_out_of_order();
      test_flush_wrap();
      test_simultaneous();
      test_multi_wb();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
